// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 keystream/decrypt stage.
// Holds the FSM state encoding, the default message length and the accepted character range.
package rc4_pkg;

    localparam int MSG_LEN_DEF = 32;

    localparam logic [7:0] CHAR_LO = 8'h61;
    localparam logic [7:0] CHAR_HI = 8'h7A;
    localparam logic [7:0] CHAR_SP = 8'h20;

    typedef enum logic [3:0] {
        IDLE,
        INC_I,
        WAIT_SI,
        READ_SJ,
        WAIT_SJ,
        SWAP_I,
        SWAP_J,
        READ_F,
        WAIT_F,
        WRITE_D,
        DONE
    } prga_state_t;

    // A one-entry message still needs a 1-bit address bus.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rc4_char_check.sv
// Combinational plaintext validator: accepts lowercase ASCII letters and space.
module rc4_char_check
    import rc4_pkg::*;
(
    input  logic [7:0] data_i,
    output logic       valid_o
);

    assign valid_o = ((data_i >= CHAR_LO) && (data_i <= CHAR_HI)) || (data_i == CHAR_SP);

endmodule

// File: rtl/prga_decrypt.sv
// RC4 PRGA decrypt engine: walks the scheduled S array, XORs the keystream with the encrypted ROM
// and writes plaintext to the result RAM. Memory outputs are registered, so each read waits one extra cycle.
module prga_decrypt
    import rc4_pkg::*;
#(
    parameter int MSG_LEN    = MSG_LEN_DEF,
    parameter int CHECK_TEXT = 1,
    localparam int AW        = addr_w(MSG_LEN)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    output logic [7:0]    s_addr,
    output logic [7:0]    s_wdata,
    output logic          s_wren,
    input  logic [7:0]    s_rdata,
    output logic [AW-1:0] rom_addr,
    input  logic [7:0]    rom_rdata,
    output logic [AW-1:0] d_addr,
    output logic [7:0]    d_wdata,
    output logic          d_wren,
    output logic          done,
    output logic          fail,
    input  logic [7:0]    ksa_s_addr,
    input  logic [7:0]    ksa_s_wdata,
    input  logic          ksa_s_wren
);

    localparam logic [AW-1:0] K_LAST = AW'(MSG_LEN - 1);

    prga_state_t   state_q;
    logic [7:0]    i_q, j_q, si_q, sj_q;
    logic [AW-1:0] k_q;
    logic [7:0]    s_addr_q, s_wdata_q;
    logic          s_wren_q;
    logic [AW-1:0] rom_addr_q, d_addr_q;
    logic [7:0]    d_wdata_q;
    logic          d_wren_q, done_q, fail_q;

    logic [7:0] j_d;
    logic [7:0] dec_byte;
    logic       char_ok, dec_ok;

    assign j_d      = j_q + s_rdata;
    assign dec_byte = s_rdata ^ rom_rdata;
    assign dec_ok   = (CHECK_TEXT != 0) ? char_ok : 1'b1;

    rc4_char_check u_char_check (
        .data_i  (dec_byte),
        .valid_o (char_ok)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            i_q        <= '0;
            j_q        <= '0;
            k_q        <= '0;
            si_q       <= '0;
            sj_q       <= '0;
            s_addr_q   <= '0;
            s_wdata_q  <= '0;
            s_wren_q   <= 1'b0;
            rom_addr_q <= '0;
            d_addr_q   <= '0;
            d_wdata_q  <= '0;
            d_wren_q   <= 1'b0;
            done_q     <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            s_wren_q <= 1'b0;
            d_wren_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        i_q     <= '0;
                        j_q     <= '0;
                        k_q     <= '0;
                        state_q <= INC_I;
                    end
                end
                INC_I: begin
                    i_q        <= i_q + 8'd1;
                    s_addr_q   <= i_q + 8'd1;
                    rom_addr_q <= k_q;
                    state_q    <= WAIT_SI;
                end
                WAIT_SI: state_q <= READ_SJ;
                READ_SJ: begin
                    si_q     <= s_rdata;
                    j_q      <= j_d;
                    s_addr_q <= j_d;
                    state_q  <= WAIT_SJ;
                end
                WAIT_SJ: state_q <= SWAP_I;
                // When i==j both writes carry the same byte, so no special case is needed.
                SWAP_I: begin
                    sj_q      <= s_rdata;
                    s_addr_q  <= i_q;
                    s_wdata_q <= s_rdata;
                    s_wren_q  <= 1'b1;
                    state_q   <= SWAP_J;
                end
                SWAP_J: begin
                    s_addr_q  <= j_q;
                    s_wdata_q <= si_q;
                    s_wren_q  <= 1'b1;
                    state_q   <= READ_F;
                end
                READ_F: begin
                    s_addr_q <= si_q + sj_q;
                    state_q  <= WAIT_F;
                end
                WAIT_F: state_q <= WRITE_D;
                WRITE_D: begin
                    d_addr_q  <= k_q;
                    d_wdata_q <= dec_byte;
                    if (!dec_ok) begin
                        fail_q  <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        d_wren_q <= 1'b1;
                        if (k_q == K_LAST) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            k_q     <= k_q + AW'(1);
                            state_q <= INC_I;
                        end
                    end
                end
                DONE: begin
                    if (!start) begin
                        done_q  <= 1'b0;
                        fail_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // The key-scheduling stage owns the S port whenever start is low; reset forces the idle (zero) registers.
    assign s_addr   = (start || !reset_n) ? s_addr_q  : ksa_s_addr;
    assign s_wdata  = (start || !reset_n) ? s_wdata_q : ksa_s_wdata;
    assign s_wren   = (start || !reset_n) ? s_wren_q  : ksa_s_wren;

    assign rom_addr = rom_addr_q;
    assign d_addr   = d_addr_q;
    assign d_wdata  = d_wdata_q;
    assign d_wren   = d_wren_q;
    assign done     = done_q;
    assign fail     = fail_q;

endmodule

// File: tb/tb_prga_decrypt.sv
// Bench for prga_decrypt: two instances (text check on/off) share stimulus, each with its own S/D memories.
`timescale 1ns/1ps
module tb_prga_decrypt;
    import rc4_pkg::*;

    localparam int N  = 32;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic reset_n, start;
    logic [7:0] ksa_addr, ksa_wdata;
    logic ksa_wren;

    logic [7:0]    s_addr_a, s_wdata_a, s_rdata_a, rom_rdata_a, d_wdata_a;
    logic          s_wren_a, d_wren_a, done_a, fail_a;
    logic [AW-1:0] rom_addr_a, d_addr_a;
    logic [7:0]    s_addr_b, s_wdata_b, s_rdata_b, rom_rdata_b, d_wdata_b;
    logic          s_wren_b, d_wren_b, done_b, fail_b;
    logic [AW-1:0] rom_addr_b, d_addr_b;

    logic [7:0] s_mem_a [256];
    logic [7:0] s_mem_b [256];
    logic [7:0] d_mem_a [N];
    logic [7:0] d_mem_b [N];
    logic [7:0] rom_mem [N];

    logic [7:0] s0 [256];
    logic [7:0] m_s [256];
    logic [7:0] ks [N];
    logic [7:0] plain [N];

    logic [15:0] q_a [$];
    logic [15:0] q_b [$];

    int checks = 0, errors = 0;
    int wr_a = 0, wr_b = 0, overlap = 0;
    logic snap_en = 1'b0;
    logic [7:0] snap2 = 8'h00, snap3 = 8'h00;

    typedef struct {
        logic        use_key;
        logic [23:0] key;
        int          corrupt;
        logic [7:0]  cval;
        logic        exp_fail;
        int          exp_edge;
    } vec_t;
    vec_t vecs [7];

    always #5 clk = ~clk;

    prga_decrypt #(.MSG_LEN(N), .CHECK_TEXT(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start),
        .s_addr(s_addr_a), .s_wdata(s_wdata_a), .s_wren(s_wren_a), .s_rdata(s_rdata_a),
        .rom_addr(rom_addr_a), .rom_rdata(rom_rdata_a),
        .d_addr(d_addr_a), .d_wdata(d_wdata_a), .d_wren(d_wren_a),
        .done(done_a), .fail(fail_a),
        .ksa_s_addr(ksa_addr), .ksa_s_wdata(ksa_wdata), .ksa_s_wren(ksa_wren)
    );

    prga_decrypt #(.MSG_LEN(N), .CHECK_TEXT(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start),
        .s_addr(s_addr_b), .s_wdata(s_wdata_b), .s_wren(s_wren_b), .s_rdata(s_rdata_b),
        .rom_addr(rom_addr_b), .rom_rdata(rom_rdata_b),
        .d_addr(d_addr_b), .d_wdata(d_wdata_b), .d_wren(d_wren_b),
        .done(done_b), .fail(fail_b),
        .ksa_s_addr(ksa_addr), .ksa_s_wdata(ksa_wdata), .ksa_s_wren(ksa_wren)
    );

    // Synchronous-read memories with one cycle of latency.
    always @(posedge clk) begin
        if (s_wren_a) s_mem_a[s_addr_a] <= s_wdata_a;
        s_rdata_a   <= s_mem_a[s_addr_a];
        rom_rdata_a <= rom_mem[rom_addr_a];
        if (d_wren_a) d_mem_a[d_addr_a] <= d_wdata_a;
        if (s_wren_b) s_mem_b[s_addr_b] <= s_wdata_b;
        s_rdata_b   <= s_mem_b[s_addr_b];
        rom_rdata_b <= rom_mem[rom_addr_b];
        if (d_wren_b) d_mem_b[d_addr_b] <= d_wdata_b;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (d_wren_a) begin
            wr_a++;
            if (snap_en && d_addr_a == 5'd1) begin
                snap2 = s_mem_a[2];
                snap3 = s_mem_a[3];
            end
            if (q_a.size() == 0) check("sb_a_extra", {d_addr_a, d_wdata_a}, 64'hFFFF);
            else check("sb_a", {3'b000, d_addr_a, d_wdata_a}, q_a.pop_front());
        end
        if (d_wren_b) begin
            wr_b++;
            if (q_b.size() == 0) check("sb_b_extra", {d_addr_b, d_wdata_b}, 64'hFFFF);
            else check("sb_b", {3'b000, d_addr_b, d_wdata_b}, q_b.pop_front());
        end
        if ((s_wren_a && d_wren_a) || (s_wren_b && d_wren_b)) overlap++;
    end

    task automatic build_s(input logic use_key, input logic [23:0] key);
        logic [7:0] j, t, kb;
        for (int n = 0; n < 256; n++) s0[n] = n[7:0];
        if (use_key) begin
            j = 8'h00;
            for (int n = 0; n < 256; n++) begin
                kb = (n % 3 == 0) ? key[23:16] : (n % 3 == 1) ? key[15:8] : key[7:0];
                j = j + s0[n] + kb;
                t = s0[n]; s0[n] = s0[j]; s0[j] = t;
            end
        end
    endtask

    task automatic model(input int nbytes);
        logic [7:0] i, j, t;
        for (int n = 0; n < 256; n++) m_s[n] = s0[n];
        i = 8'h00; j = 8'h00;
        for (int k = 0; k < nbytes; k++) begin
            i = i + 8'd1;
            j = j + m_s[i];
            t = m_s[i]; m_s[i] = m_s[j]; m_s[j] = t;
            t = m_s[i] + m_s[j];
            ks[k] = m_s[t];
        end
    endtask

    task automatic prepare_enc(input int corrupt, input logic [7:0] cval, output int exp_wr);
        int v;
        model(N);
        for (int k = 0; k < N; k++) begin
            v = $urandom_range(0, 26);
            plain[k] = (v == 26) ? 8'h20 : 8'h61 + v[7:0];
        end
        plain[0] = 8'h61; plain[1] = 8'h63; plain[2] = 8'h7A; plain[3] = 8'h20;
        for (int k = 0; k < N; k++) rom_mem[k] = (k == corrupt) ? (ks[k] ^ cval) : (ks[k] ^ plain[k]);
        q_a.delete();
        q_b.delete();
        exp_wr = (corrupt < 0) ? N : corrupt;
        for (int k = 0; k < exp_wr; k++) q_a.push_back({k[7:0], plain[k]});
        for (int k = 0; k < N; k++) q_b.push_back({k[7:0], rom_mem[k] ^ ks[k]});
        wr_a = 0;
        wr_b = 0;
    endtask

    task automatic load_s();
        start = 1'b0;
        for (int n = 0; n < 256; n++) begin
            @(negedge clk);
            ksa_addr = n[7:0]; ksa_wdata = s0[n]; ksa_wren = 1'b1;
        end
        @(negedge clk);
        ksa_addr = 8'h00; ksa_wdata = 8'h00; ksa_wren = 1'b0;
    endtask

    task automatic wait_done(output int ea, output int eb);
        ea = 0; eb = 0;
        for (int c = 1; c <= 400 && (ea == 0 || eb == 0); c++) begin
            @(posedge clk); #1;
            if (ea == 0 && done_a) ea = c;
            if (eb == 0 && done_b) eb = c;
        end
    endtask

    task automatic check_final_s(input string name, input logic use_a);
        int bad = 0;
        for (int n = 0; n < 256; n++) begin
            if (use_a && s_mem_a[n] !== m_s[n]) bad++;
            if (!use_a && s_mem_b[n] !== m_s[n]) bad++;
        end
        check(name, bad, 0);
    endtask

    task automatic run_vec(input int v);
        int ewr, ea, eb, hold_bad;
        build_s(vecs[v].use_key, vecs[v].key);
        load_s();
        prepare_enc(vecs[v].corrupt, vecs[v].cval, ewr);
        snap_en = (v == 0);
        @(negedge clk);
        start = 1'b1;
        wait_done(ea, eb);
        check("done_edge_a", ea, vecs[v].exp_edge);
        check("done_edge_b", eb, 289);
        check("fail_a", fail_a, vecs[v].exp_fail);
        check("fail_b", fail_b, 0);
        @(posedge clk); #1;
        check("writes_a", wr_a, ewr);
        check("writes_b", wr_b, N);
        check("sb_left", q_a.size() + q_b.size(), 0);
        check_final_s("s_final_b", 1'b0);
        if (vecs[v].corrupt < 0) check_final_s("s_final_a", 1'b1);
        if (v == 0) begin
            check("d0_a", d_mem_a[0], 8'h61);
            check("d1_a", d_mem_a[1], 8'h63);
            check("s2_after_b1", snap2, 8'h03);
            check("s3_after_b1", snap3, 8'h02);
            hold_bad = 0;
            for (int c = 0; c < 20; c++) begin
                @(posedge clk); #1;
                if (!done_a || !done_b || s_wren_a || s_wren_b || d_wren_a || d_wren_b) hold_bad++;
            end
            check("hold_in_done", hold_bad, 0);
            check("hold_writes", wr_a + wr_b, 2 * N);
        end
        if (v == 2) check("nocheck_d0", d_mem_b[0], 8'h02);
        snap_en = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        check("idle_after_done", {done_a, fail_a, done_b, fail_b}, 0);
    endtask

    initial begin
        int ewr, ea, eb;
        vecs[0] = '{1'b0, 24'h000000, -1, 8'h00, 1'b0, 289};
        vecs[1] = '{1'b1, 24'h000249, -1, 8'h00, 1'b0, 289};
        vecs[2] = '{1'b0, 24'h000000,  0, 8'h02, 1'b1, 10};
        vecs[3] = '{1'b1, 24'h000249,  5, 8'h7B, 1'b1, 55};
        vecs[4] = '{1'b1, 24'h123456, 31, 8'h60, 1'b1, 289};
        vecs[5] = '{1'b1, 24'hABCDEF, 10, 8'h41, 1'b1, 100};
        vecs[6] = '{1'b1, 24'h5A0F33, -1, 8'h00, 1'b0, 289};

        reset_n = 1'b1; start = 1'b0;
        ksa_addr = 8'h5A; ksa_wdata = 8'hC3; ksa_wren = 1'b1;
        #2 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_a", {s_addr_a, s_wdata_a, s_wren_a, rom_addr_a, d_addr_a, d_wdata_a, d_wren_a, done_a, fail_a}, 0);
        check("rst_out_b", {s_addr_b, s_wdata_b, s_wren_b, rom_addr_b, d_addr_b, d_wdata_b, d_wren_b, done_b, fail_b}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        ksa_addr = 8'hA5; ksa_wdata = 8'h3C; ksa_wren = 1'b0;
        #1;
        check("ksa_mux", {s_addr_a, s_wdata_b, s_wren_a}, {8'hA5, 8'h3C, 1'b0});
        ksa_addr = 8'h00; ksa_wdata = 8'h00;

        for (int v = 0; v < 7; v++) run_vec(v);

        // Reset in SWAP_I of byte 5, then restart on the partly-permuted S.
        build_s(1'b1, 24'h000249);
        load_s();
        prepare_enc(-1, 8'h00, ewr);
        @(negedge clk);
        start = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        check("pre_rst_writes", wr_a, 5);
        reset_n = 1'b0;
        #1;
        check("rst_mid_a", {s_addr_a, s_wdata_a, s_wren_a, rom_addr_a, d_addr_a, d_wdata_a, d_wren_a, done_a, fail_a}, 0);
        check("rst_mid_b", {s_addr_b, s_wdata_b, s_wren_b, rom_addr_b, d_addr_b, d_wdata_b, d_wren_b, done_b, fail_b}, 0);
        model(5);
        for (int n = 0; n < 256; n++) s0[n] = m_s[n];
        prepare_enc(-1, 8'h00, ewr);
        repeat (3) @(posedge clk);
        #1;
        check("writes_in_rst", wr_a + wr_b, 0);
        @(negedge clk);
        reset_n = 1'b1;
        wait_done(ea, eb);
        check("rerun_edge_a", ea, 289);
        check("rerun_edge_b", eb, 289);
        check("rerun_fail_a", fail_a, 0);
        @(posedge clk); #1;
        check("rerun_writes", {wr_a, wr_b}, {32'(N), 32'(N)});
        check_final_s("rerun_s_a", 1'b1);
        check_final_s("rerun_s_b", 1'b0);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;

        check("wren_overlap", overlap, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
